// File: rtl/t02_writeback_unit_if.sv
// Writeback bundle: ALU/load completion inputs, decode source indices, and register-file write port.
// The unit takes the slave view; upstream logic takes the master view.
interface t02_writeback_unit_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        load_req;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic        load_busy;
  logic        stall;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output load_req, load_rd, load_funct3, load_addr_lo,
    output mem_ack, mem_rdata, rs1, rs2,
    input  reg_write, write_index, write_data, load_busy, stall
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  load_req, load_rd, load_funct3, load_addr_lo,
    input  mem_ack, mem_rdata, rs1, rs2,
    output reg_write, write_index, write_data, load_busy, stall
  );
endinterface

// File: rtl/t02_writeback_unit.sv
// Register-file writeback: merges ALU results and one outstanding load, 1-cycle registered write.
// No backpressure on writes; a one-entry hold buffer absorbs ALU/load collisions and raises stall.
module t02_writeback_unit (
  input  logic                  clk,
  input  logic                  nRST,
  t02_writeback_unit_if.slave   bus
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state_q, state_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [2:0]  pend_f3_q, pend_f3_d;
  logic [1:0]  pend_off_q, pend_off_d;
  logic        hold_valid_q, hold_valid_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_index_q, write_index_d;
  logic [31:0] write_data_q, write_data_d;

  logic        stall;
  logic        load_fire;
  logic        alu_take;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  always_comb begin
    ld_byte = bus.mem_rdata[7:0];
    case (pend_off_q)
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      2'd3:    ld_byte = bus.mem_rdata[31:24];
      default: ld_byte = bus.mem_rdata[7:0];
    endcase
    ld_half = pend_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (pend_f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // Load-use hazard only exists for a live, non-x0 destination.
  assign stall = hold_valid_q |
                 ((state_q == WAIT_MEM) && (pend_rd_q != 5'd0) &&
                  ((bus.rs1 == pend_rd_q) || (bus.rs2 == pend_rd_q)));

  assign load_fire = (state_q == WAIT_MEM) && bus.mem_ack;
  assign alu_take  = bus.alu_valid && !stall && (bus.alu_rd != 5'd0);

  always_comb begin
    state_d       = state_q;
    pend_rd_d     = pend_rd_q;
    pend_f3_d     = pend_f3_q;
    pend_off_d    = pend_off_q;
    hold_valid_d  = hold_valid_q;
    hold_rd_d     = hold_rd_q;
    hold_data_d   = hold_data_q;
    reg_write_d   = 1'b0;
    write_index_d = write_index_q;
    write_data_d  = write_data_q;

    case (state_q)
      IDLE: begin
        if (bus.load_req) begin
          state_d    = WAIT_MEM;
          pend_rd_d  = bus.load_rd;
          pend_f3_d  = bus.load_funct3;
          pend_off_d = bus.load_addr_lo;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load data wins the port; a colliding ALU result parks in the hold buffer.
    if (load_fire) begin
      if (pend_rd_q != 5'd0) begin
        reg_write_d   = 1'b1;
        write_index_d = pend_rd_q;
        write_data_d  = load_data;
      end
      if (alu_take) begin
        hold_valid_d = 1'b1;
        hold_rd_d    = bus.alu_rd;
        hold_data_d  = bus.alu_result;
      end
    end else if (hold_valid_q) begin
      reg_write_d   = 1'b1;
      write_index_d = hold_rd_q;
      write_data_d  = hold_data_q;
      hold_valid_d  = 1'b0;
    end else if (alu_take) begin
      reg_write_d   = 1'b1;
      write_index_d = bus.alu_rd;
      write_data_d  = bus.alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q       <= IDLE;
      pend_rd_q     <= 5'd0;
      pend_f3_q     <= 3'd0;
      pend_off_q    <= 2'd0;
      hold_valid_q  <= 1'b0;
      hold_rd_q     <= 5'd0;
      hold_data_q   <= 32'd0;
      reg_write_q   <= 1'b0;
      write_index_q <= 5'd0;
      write_data_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      pend_rd_q     <= pend_rd_d;
      pend_f3_q     <= pend_f3_d;
      pend_off_q    <= pend_off_d;
      hold_valid_q  <= hold_valid_d;
      hold_rd_q     <= hold_rd_d;
      hold_data_q   <= hold_data_d;
      reg_write_q   <= reg_write_d;
      write_index_q <= write_index_d;
      write_data_q  <= write_data_d;
    end
  end

  assign bus.reg_write   = reg_write_q;
  assign bus.write_index = write_index_q;
  assign bus.write_data  = write_data_q;
  assign bus.load_busy   = (state_q == WAIT_MEM);
  assign bus.stall       = stall;
endmodule

// File: tb/tb_t02_writeback_unit.sv
// Directed bench for t02_writeback_unit: table of ALU/load write vectors plus hand-written
// sequences for reset, hazard stall, ALU/load collision and reset during an outstanding load.
module tb_t02_writeback_unit;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  t02_writeback_unit_if bus ();

  t02_writeback_unit dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid    = 1'b0;
    bus.alu_rd       = 5'd0;
    bus.alu_result   = 32'd0;
    bus.load_req     = 1'b0;
    bus.load_rd      = 5'd0;
    bus.load_funct3  = 3'd0;
    bus.load_addr_lo = 2'd0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = 32'd0;
    bus.rs1          = 5'd0;
    bus.rs2          = 5'd0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    bus.load_req     = 1'b1;
    bus.load_rd      = rd;
    bus.load_funct3  = f3;
    bus.load_addr_lo = off;
    step();
    bus.load_req     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd5,  3'b000, 2'd0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0,  3'b000, 2'd0, 32'h00001234, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 5'd1,  3'b000, 2'd3, 32'h80FF7F01, 1'b1, 32'hFFFFFF80};
    vecs[3]  = '{1'b1, 5'd2,  3'b100, 2'd3, 32'h80FF7F01, 1'b1, 32'h00000080};
    vecs[4]  = '{1'b1, 5'd3,  3'b001, 2'd2, 32'h80FF7F01, 1'b1, 32'hFFFF80FF};
    vecs[5]  = '{1'b1, 5'd4,  3'b101, 2'd0, 32'h80FF7F01, 1'b1, 32'h00007F01};
    vecs[6]  = '{1'b1, 5'd6,  3'b010, 2'd0, 32'h80FF7F01, 1'b1, 32'h80FF7F01};
    vecs[7]  = '{1'b1, 5'd8,  3'b000, 2'd2, 32'h80FF7F01, 1'b1, 32'hFFFFFFFF};
    vecs[8]  = '{1'b1, 5'd9,  3'b100, 2'd1, 32'h80FF7F01, 1'b1, 32'h0000007F};
    vecs[9]  = '{1'b1, 5'd10, 3'b000, 2'd0, 32'h80FF7F01, 1'b1, 32'h00000001};
    vecs[10] = '{1'b1, 5'd11, 3'b101, 2'd2, 32'h80FF7F01, 1'b1, 32'h000080FF};
    vecs[11] = '{1'b1, 5'd12, 3'b001, 2'd0, 32'h00008000, 1'b1, 32'hFFFF8000};
    vecs[12] = '{1'b1, 5'd13, 3'b011, 2'd1, 32'h80FF7F01, 1'b1, 32'h80FF7F01};
    vecs[13] = '{1'b1, 5'd14, 3'b110, 2'd3, 32'h12345678, 1'b1, 32'h12345678};
    vecs[14] = '{1'b1, 5'd0,  3'b010, 2'd0, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 5'd31, 3'b000, 2'd0, 32'h0000000B, 1'b1, 32'h0000000B};

    idle_inputs();
    nRST = 1'b0;
    step();
    step();
    chk("reset reg_write",   {31'd0, bus.reg_write},   32'd0);
    chk("reset write_index", {27'd0, bus.write_index}, 32'd0);
    chk("reset write_data",  bus.write_data,           32'd0);
    chk("reset stall",       {31'd0, bus.stall},       32'd0);
    chk("reset load_busy",   {31'd0, bus.load_busy},   32'd0);
    nRST = 1'b1;
    step();

    // ALU write is a one-cycle pulse; index/data hold afterwards.
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd5;
    bus.alu_result = 32'hDEADBEEF;
    step();
    idle_inputs();
    chk("alu N+1 reg_write",   {31'd0, bus.reg_write},   32'd1);
    chk("alu N+1 write_index", {27'd0, bus.write_index}, 32'd5);
    chk("alu N+1 write_data",  bus.write_data,           32'hDEADBEEF);
    step();
    chk("alu N+2 reg_write",   {31'd0, bus.reg_write},   32'd0);
    chk("alu N+2 index held",  {27'd0, bus.write_index}, 32'd5);
    chk("alu N+2 data held",   bus.write_data,           32'hDEADBEEF);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_load) begin
        issue_load(vecs[i].rd, vecs[i].f3, vecs[i].off);
        chk($sformatf("vec%0d load_busy", i), {31'd0, bus.load_busy}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = vecs[i].data;
        step();
        bus.mem_ack   = 1'b0;
        chk($sformatf("vec%0d busy cleared", i), {31'd0, bus.load_busy}, 32'd0);
      end else begin
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = vecs[i].rd;
        bus.alu_result = vecs[i].data;
        step();
        bus.alu_valid  = 1'b0;
      end
      chk($sformatf("vec%0d reg_write", i), {31'd0, bus.reg_write}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d write_index", i), {27'd0, bus.write_index}, {27'd0, vecs[i].rd});
        chk($sformatf("vec%0d write_data", i), bus.write_data, vecs[i].exp_data);
      end
      step();
    end

    // Load to x0 never stalls even when a source reads x0.
    bus.rs1 = 5'd0;
    issue_load(5'd0, 3'b010, 2'd0);
    #1;
    chk("x0 load stall", {31'd0, bus.stall}, 32'd0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("x0 load reg_write", {31'd0, bus.reg_write}, 32'd0);
    step();

    // Load-use hazard on rd 7.
    issue_load(5'd7, 3'b010, 2'd0);
    bus.rs2 = 5'd7;
    #1;
    chk("hazard rs2 stall", {31'd0, bus.stall}, 32'd1);
    step();
    chk("hazard held stall", {31'd0, bus.stall}, 32'd1);
    bus.rs1 = 5'd8;
    bus.rs2 = 5'd8;
    #1;
    chk("hazard unrelated stall", {31'd0, bus.stall}, 32'd0);
    bus.rs1 = 5'd7;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00000077;
    #1;
    chk("hazard ack-cycle stall", {31'd0, bus.stall}, 32'd1);
    step();
    bus.mem_ack = 1'b0;
    chk("hazard after ack stall", {31'd0, bus.stall}, 32'd0);
    chk("hazard write_index", {27'd0, bus.write_index}, 32'd7);
    chk("hazard write_data", bus.write_data, 32'h00000077);
    idle_inputs();
    step();

    // Collision: load (rd 3) and ALU (rd 4) complete together.
    issue_load(5'd3, 3'b010, 2'd0);
    bus.mem_ack    = 1'b1;
    bus.mem_rdata  = 32'h0000000A;
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd4;
    bus.alu_result = 32'h0000000B;
    step();
    idle_inputs();
    chk("coll N+1 reg_write",   {31'd0, bus.reg_write},   32'd1);
    chk("coll N+1 write_index", {27'd0, bus.write_index}, 32'd3);
    chk("coll N+1 write_data",  bus.write_data,           32'h0000000A);
    chk("coll N+1 stall",       {31'd0, bus.stall},       32'd1);
    step();
    chk("coll N+2 reg_write",   {31'd0, bus.reg_write},   32'd1);
    chk("coll N+2 write_index", {27'd0, bus.write_index}, 32'd4);
    chk("coll N+2 write_data",  bus.write_data,           32'h0000000B);
    step();
    chk("coll N+3 stall",       {31'd0, bus.stall},       32'd0);
    chk("coll N+3 reg_write",   {31'd0, bus.reg_write},   32'd0);

    // Reset while a load is outstanding; the late ack must be ignored.
    issue_load(5'd9, 3'b010, 2'd0);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("midrst load_busy", {31'd0, bus.load_busy}, 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00000055;
    step();
    bus.mem_ack = 1'b0;
    chk("midrst reg_write",   {31'd0, bus.reg_write},   32'd0);
    chk("midrst write_index", {27'd0, bus.write_index}, 32'd0);
    chk("midrst write_data",  bus.write_data,           32'd0);
    chk("midrst load_busy2",  {31'd0, bus.load_busy},   32'd0);
    chk("midrst stall",       {31'd0, bus.stall},       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
